window_crop: RTL
================

// Module: window_crop
// PURPOSE
// Runtime-configurable, multi-channel crop/decimate stage for the camera pixel pipeline.
// Replaces fixed-coordinate cropping for pan (raw Bayer) and zoom (RGB) windows.
// Window and decimation are SPI-driven, shadowed, and applied only at frame boundaries.
// Sits between byte-to-pixel/debayer stages and the metering/JPEG stages.
// PARAMETERS
// CHANNELS     3   data channels per pixel (1 = raw Bayer, 3 = RGB)
// DATA_WIDTH   10  bits per channel
// COORD_WIDTH  11  width of x/y counters and window coordinates
// BAYER_MODE   0   1 = enforce 2x2 Bayer-quad alignment and pairwise decimation
// PORTS
// pixel_clock_in     in   1                     pixel clock
// mipi_byte_reset_n  in   1                     reset, asynchronous, active-low
// data_in            in   CHANNELS*DATA_WIDTH   pixel data, channel 0 in LSBs
// line_valid_in      in   1                     input line valid
// frame_valid_in     in   1                     input frame valid
// x_start_in         in   COORD_WIDTH           first kept column (inclusive)
// x_end_in           in   COORD_WIDTH           last kept column + 1 (exclusive)
// y_start_in         in   COORD_WIDTH           first kept line (inclusive)
// y_end_in           in   COORD_WIDTH           last kept line + 1 (exclusive)
// decimation_in      in   2                     keep 1 of every 2^d pixels/lines (d = 0..3)
// config_valid_in    in   1                     one-cycle pulse: capture window inputs into pending
// data_out           out  CHANNELS*DATA_WIDTH   cropped data, 0 when line_valid_out low
// line_valid_out     out  1                     kept pixel strobe
// frame_valid_out    out  1                     frame_valid_in delayed 1 cycle (ACTIVE frames only)
// config_error_out   out  1                     sticky: last applied pending config was rejected
// frame_count_out    out  16                    completed cropped frames, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset (async): all outputs 0; x/y counters 0; pending and active config =
//   {x 0..2^CW-1, y 0..2^CW-1, d=0} (pass-through); pending_dirty=0; state WAIT_IDLE.
// - FSM:
//   - WAIT_IDLE -> IDLE when frame_valid_in=0. Reset mid-frame never emits a partial frame.
//   - IDLE -> ACTIVE on frame_valid_in rising. In the same cycle, if pending_dirty:
//     - pending valid: copy pending to active; clear config_error_out.
//     - pending invalid: keep active; set config_error_out.
//     - Both cases clear pending_dirty.
//   - ACTIVE -> IDLE on frame_valid_in falling; frame_count_out += 1 in that cycle.
// - Pending validity:
//   - x_start < x_end and y_start < y_end.
//   - If BAYER_MODE: all four coordinates even.
// - config_valid_in: writes pending and sets pending_dirty in any state.
//   A pulse coinciding with frame_valid_in rising updates pending only;
//   active takes the old pending value, and the new one applies next frame (pending_dirty stays 1).
// - x counter: increments each cycle line_valid_in=1 in ACTIVE; cleared on line_valid_in falling;
//   saturates at 2^CW-1 (no wrap).
// - y counter: increments on line_valid_in falling in ACTIVE; cleared on entry to ACTIVE;
//   saturates at 2^CW-1.
// - Keep pixel iff all hold:
//   - line_valid_in=1, x_start<=x<x_end, y_start<=y<y_end.
//   - ((x-x_start)>>b) mod 2^d == 0 and ((y-y_start)>>b) mod 2^d == 0,
//     where b=1 if BAYER_MODE else 0.
// - Kept pixel: line_valid_out=1 and data_out=data_in, exactly 1 cycle later (registered).
//   Otherwise line_valid_out=0 and data_out=0.
// - Output width per line = ceil((x_end-x_start)/2^d) (non-Bayer).
//   BAYER_MODE: kept pixels are pairs every 2*2^d columns.
// - Input pixels arriving in IDLE or WAIT_IDLE are dropped; frame_valid_out stays 0.
// - Window extending past the sensor edge: output truncated to the available pixels; no error.
// TESTING
// - Reset, config x 2..6, y 1..3, d=0, then an 8x5 frame (data=x+16*y)
//   -> frame 2: 4x2 output 0x12..0x15, 0x22..0x25; frame_count_out=2.
// - config d=1, x 0..8, y 0..4 on an 8x4 frame -> lines 0,2 kept;
//   columns 0,2,4,6 kept; 8 strobes total.
// - BAYER_MODE=1, x_start=3 -> config_error_out=1 at next frame start; previous window still used.
//   Then a valid config -> error clears at following frame start.
// - config_valid_in pulse on the same cycle as frame_valid_in rising
//   -> old pending used for this frame, new window applied on the next frame.
// - Assert reset mid-line of an active frame -> outputs 0 immediately;
//   no output until frame_valid_in low then high again.
// - Frame with 2100 pixels/line, COORD_WIDTH=11 -> x saturates at 2047;
//   no wrap-around re-entry into the window.

Source files
------------

// File: rtl/window_crop.sv
// window_crop: runtime crop/decimate window for the camera pixel pipeline.
// The window is written to a pending copy and applied only at frame start.
module window_crop #(
    parameter int CHANNELS    = 3,
    parameter int DATA_WIDTH  = 10,
    parameter int COORD_WIDTH = 11,
    parameter int BAYER_MODE  = 0
) (
    input  logic                           pixel_clock_in,
    input  logic                           mipi_byte_reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           line_valid_in,
    input  logic                           frame_valid_in,
    input  logic [COORD_WIDTH-1:0]         x_start_in,
    input  logic [COORD_WIDTH-1:0]         x_end_in,
    input  logic [COORD_WIDTH-1:0]         y_start_in,
    input  logic [COORD_WIDTH-1:0]         y_end_in,
    input  logic [1:0]                     decimation_in,
    input  logic                           config_valid_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           line_valid_out,
    output logic                           frame_valid_out,
    output logic                           config_error_out,
    output logic [15:0]                    frame_count_out
);
    localparam int DW = CHANNELS * DATA_WIDTH;
    localparam int CW = COORD_WIDTH;
    localparam logic [CW-1:0] C_MAX = '1;
    localparam logic [CW-1:0] C_ONE = 1;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_px_start;
    logic [CW-1:0] r_px_end;
    logic [CW-1:0] r_py_start;
    logic [CW-1:0] r_py_end;
    logic [1:0]    r_p_dec;
    logic          r_p_dirty;

    logic [CW-1:0] r_ax_start;
    logic [CW-1:0] r_ax_end;
    logic [CW-1:0] r_ay_start;
    logic [CW-1:0] r_ay_end;
    logic [1:0]    r_a_dec;

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_lv_d;

    logic          r_err;
    logic [15:0]   r_fcount;
    logic          r_lv_out;
    logic          r_fv_out;
    logic [DW-1:0] r_data_out;

    logic          w_frame_start;
    logic          w_frame_end;
    logic          w_even;
    logic          w_pend_ok;
    logic [CW-1:0] w_dx;
    logic [CW-1:0] w_dy;
    logic [CW-1:0] w_dx_s;
    logic [CW-1:0] w_dy_s;
    logic [CW-1:0] w_dmask;
    logic          w_in_x;
    logic          w_in_y;
    logic          w_dec_x;
    logic          w_dec_y;
    logic          w_keep;

    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        unique case (r_state)
            WAIT_IDLE: begin
                if (!frame_valid_in) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (frame_valid_in) begin
                    w_state_nxt   = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (!frame_valid_in) begin
                    w_state_nxt = IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_IDLE;
            end
        endcase
    end

    assign w_even = ~(r_px_start[0] | r_px_end[0] |
                      r_py_start[0] | r_py_end[0]);

    assign w_pend_ok = (r_px_start < r_px_end) &&
                       (r_py_start < r_py_end) &&
                       ((BAYER_MODE == 0) || w_even);

    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            r_px_start <= '0;
            r_px_end   <= C_MAX;
            r_py_start <= '0;
            r_py_end   <= C_MAX;
            r_p_dec    <= 2'd0;
            r_p_dirty  <= 1'b0;
            r_ax_start <= '0;
            r_ax_end   <= C_MAX;
            r_ay_start <= '0;
            r_ay_end   <= C_MAX;
            r_a_dec    <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            // Active always takes the value pending before this cycle.
            if (w_frame_start && r_p_dirty) begin
                if (w_pend_ok) begin
                    r_ax_start <= r_px_start;
                    r_ax_end   <= r_px_end;
                    r_ay_start <= r_py_start;
                    r_ay_end   <= r_py_end;
                    r_a_dec    <= r_p_dec;
                    r_err      <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (config_valid_in) begin
                r_px_start <= x_start_in;
                r_px_end   <= x_end_in;
                r_py_start <= y_start_in;
                r_py_end   <= y_end_in;
                r_p_dec    <= decimation_in;
                r_p_dirty  <= 1'b1;
            end else if (w_frame_start) begin
                r_p_dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_lv_d <= 1'b0;
        end else begin
            r_lv_d <= line_valid_in;
            if (w_frame_start) begin
                r_x <= '0;
                r_y <= '0;
            end else if (line_valid_in) begin
                if (r_state == ACTIVE && r_x != C_MAX) begin
                    r_x <= r_x + C_ONE;
                end
            end else if (r_lv_d) begin
                r_x <= '0;
                if (r_state == ACTIVE && r_y != C_MAX) begin
                    r_y <= r_y + C_ONE;
                end
            end
        end
    end

    assign w_dx    = r_x - r_ax_start;
    assign w_dy    = r_y - r_ay_start;
    assign w_dx_s  = (BAYER_MODE != 0) ? (w_dx >> 1) : w_dx;
    assign w_dy_s  = (BAYER_MODE != 0) ? (w_dy >> 1) : w_dy;
    assign w_dmask = CW'((32'd1 << r_a_dec) - 32'd1);
    assign w_in_x  = (r_x >= r_ax_start) && (r_x < r_ax_end);
    assign w_in_y  = (r_y >= r_ay_start) && (r_y < r_ay_end);
    assign w_dec_x = ((w_dx_s & w_dmask) == '0);
    assign w_dec_y = ((w_dy_s & w_dmask) == '0);
    assign w_keep  = (r_state == ACTIVE) && line_valid_in &&
                     w_in_x && w_in_y && w_dec_x && w_dec_y;

    always_ff @(posedge pixel_clock_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            r_lv_out   <= 1'b0;
            r_fv_out   <= 1'b0;
            r_data_out <= '0;
            r_fcount   <= 16'd0;
        end else begin
            r_lv_out   <= w_keep;
            r_fv_out   <= (w_state_nxt == ACTIVE);
            r_data_out <= w_keep ? data_in : '0;
            if (w_frame_end) begin
                r_fcount <= r_fcount + 16'd1;
            end
        end
    end

    assign data_out         = r_data_out;
    assign line_valid_out   = r_lv_out;
    assign frame_valid_out  = r_fv_out;
    assign config_error_out = r_err;
    assign frame_count_out  = r_fcount;

endmodule
